axi4_lite_arbiter: RTL and testbench
====================================

AXI4_LITE_ARBITER -- requirements
Module: axi4_lite_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, address width of all three ports.
REQ-002 Parameter: DATA_WIDTH, 32, data width of all ports; STRB width = DATA_WIDTH/8.
REQ-003 Port: clk  input  1  single clock for all logic.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: s0  axi4_lite_if (slave side)  bus  requester 0 (higher priority after reset).
REQ-006 Port: s1  axi4_lite_if (slave side)  bus  requester 1.
REQ-007 Port: m  axi4_lite_if (master side)  bus  shared downstream slave.
REQ-008 Port: wr_grant  output  2  one-hot write owner, 00 = idle.
REQ-009 Port: rd_grant  output  2  one-hot read owner, 00 = idle.

Function
REQ-010 Write path (AW/W/B) and read path (AR/R) SHALL be arbitrated independently; one write and one read MAY be in flight simultaneously.
REQ-011 Each path SHALL allow at most one outstanding transaction.
REQ-012 Write FSM states: W_IDLE, W_ADDR, W_RESP; read FSM states: R_IDLE, R_ADDR, R_DATA.
REQ-013 W_IDLE: on any sNawvalid=1, the FSM SHALL register a grant and enter W_ADDR next cycle (1-cycle arbitration latency); wvalid alone SHALL NOT request.
REQ-014 W_ADDR: the FSM SHALL forward the granted requester's AW and W to m and m's awready/wready back, tracking aw_done/w_done separately; when both are done it SHALL enter W_RESP.
REQ-015 W_RESP: the FSM SHALL forward m.bvalid/bresp to the granted requester and its bready to m; on the B handshake it SHALL return to W_IDLE.
REQ-016 R_IDLE/R_ADDR/R_DATA SHALL behave analogously: arvalid requests; the AR handshake moves to R_DATA; the R handshake (rdata/rresp forwarded) returns to R_IDLE.
REQ-017 The non-granted requester SHALL see awready/wready/arready=0 and bvalid/rvalid=0 on that path.
REQ-018 In IDLE states, m valids and m bready/rready SHALL be 0.
REQ-019 Round-robin: each path SHALL hold a priority pointer; when both request in the same IDLE cycle, the pointer's requester wins.
REQ-020 After each completed transaction, the pointer SHALL point to the requester that did not just complete; a lone requester SHALL win regardless of the pointer.
REQ-021 The granted requester's AW and W handshakes MAY occur in the same cycle or in either order.
REQ-022 Payload (addr, prot, data, strb, resp, rdata) SHALL pass through combinationally; no data registers.
REQ-023 Once granted, a requester SHALL keep its grant until its response handshake, whatever the other requester does.

Reset
REQ-024 While rst=1, at the clock edge: both FSMs SHALL go to IDLE, both pointers to requester 0, aw_done/w_done to 0, wr_grant/rd_grant to 00.
REQ-025 During reset, all ready and valid outputs on s0, s1 and m SHALL be 0.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction; no B or R SHALL be delivered afterwards for it.

Structure
REQ-027 Package axi4_lite_arb_pkg SHALL hold the write-state and read-state enums and the requester index type.
REQ-028 Sub-module rr_arbiter2 (2-way request/pointer -> one-hot grant, pointer update on done) SHALL be instantiated once per path.

Verification
REQ-029 Lone write: s0 AW addr=0x10 and W data=0xDEADBEEF, strb=0xF in cycle 0 -> m.awvalid in cycle 1 with the same payload; bresp=OKAY returns to s0; wr_grant=01 then 00.
REQ-030 Contention: s0 and s1 assert arvalid in the same cycle after reset -> s0 served first, then s1; repeat -> s1 first (pointer alternates).
REQ-031 Concurrent paths: s0 write and s1 read simultaneously -> wr_grant=01 and rd_grant=10 together; both complete; each requester gets only its own response.
REQ-032 Split AW/W: W handshakes 3 cycles before AW -> m.bready only in W_RESP; s1 awready stays 0 throughout.
REQ-033 Reset in W_RESP: rst asserted for 1 cycle while m.bvalid pending -> s0 bvalid=0; grants 00; the next s1 request is served normally.
REQ-034 Back-pressure: s0 holds rready=0 for 5 cycles -> m.rready=0, m.rdata held; the grant does not change.

Source files
------------

// File: rtl/axi4_lite_arb_pkg.sv
// Shared types for the two-requester AXI4-Lite arbiter: path FSM states,
// requester index and bus field widths.
package axi4_lite_arb_pkg;

  localparam int unsigned PROT_WIDTH = 3;
  localparam int unsigned RESP_WIDTH = 2;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef logic req_idx_t;

  function automatic logic [1:0] idx_to_onehot(input req_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle; master drives requests, slave drives responses.
interface axi4_lite_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0]                     awaddr;
  logic [axi4_lite_arb_pkg::PROT_WIDTH-1:0]  awprot;
  logic                                      awvalid;
  logic                                      awready;
  logic [DATA_WIDTH-1:0]                     wdata;
  logic [STRB_WIDTH-1:0]                     wstrb;
  logic                                      wvalid;
  logic                                      wready;
  logic [axi4_lite_arb_pkg::RESP_WIDTH-1:0]  bresp;
  logic                                      bvalid;
  logic                                      bready;
  logic [ADDR_WIDTH-1:0]                     araddr;
  logic [axi4_lite_arb_pkg::PROT_WIDTH-1:0]  arprot;
  logic                                      arvalid;
  logic                                      arready;
  logic [DATA_WIDTH-1:0]                     rdata;
  logic [axi4_lite_arb_pkg::RESP_WIDTH-1:0]  rresp;
  logic                                      rvalid;
  logic                                      rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant from request and
// priority pointer; pointer moves to the other requester when a transaction ends.
module rr_arbiter2
  import axi4_lite_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_done,
  input  req_idx_t   i_done_idx,
  output logic [1:0] o_grant_c,
  output req_idx_t   o_idx_c
);

  req_idx_t r_ptr;

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    o_idx_c = r_ptr;
    case (i_req)
      2'b01:   o_idx_c = 1'b0;
      2'b10:   o_idx_c = 1'b1;
      default: o_idx_c = r_ptr;
    endcase
    o_grant_c = (|i_req) ? idx_to_onehot(o_idx_c) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (i_done) begin
      r_ptr <= ~i_done_idx;
    end
  end

endmodule

// File: rtl/axi4_lite_arbiter.sv
// Two-requester AXI4-Lite arbiter onto one downstream slave; write and read
// paths are arbitrated independently, one outstanding transaction each.
module axi4_lite_arbiter
  import axi4_lite_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  axi4_lite_if.slave  s0,
  axi4_lite_if.slave  s1,
  axi4_lite_if.master m,
  output logic [1:0]  wr_grant,
  output logic [1:0]  rd_grant
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  wr_state_e  r_wr_state, w_wr_state_nxt;
  req_idx_t   r_wr_idx, w_wr_idx_nxt, w_wr_arb_idx;
  logic [1:0] r_wr_grant, w_wr_grant_nxt, w_wr_arb_grant, w_wr_req;
  logic       r_aw_done, r_w_done, w_aw_done_nxt, w_w_done_nxt;
  logic       w_aw_fwd, w_w_fwd, w_b_fwd, w_wr_done;
  logic       w_sel_awvalid, w_sel_wvalid, w_sel_bready;

  rd_state_e  r_rd_state, w_rd_state_nxt;
  req_idx_t   r_rd_idx, w_rd_idx_nxt, w_rd_arb_idx;
  logic [1:0] r_rd_grant, w_rd_grant_nxt, w_rd_arb_grant, w_rd_req;
  logic       w_ar_fwd, w_r_fwd, w_rd_done;
  logic       w_sel_arvalid, w_sel_rready;

  assign w_wr_req      = {s1.awvalid, s0.awvalid};
  assign w_rd_req      = {s1.arvalid, s0.arvalid};
  assign w_sel_awvalid = r_wr_idx ? s1.awvalid : s0.awvalid;
  assign w_sel_wvalid  = r_wr_idx ? s1.wvalid  : s0.wvalid;
  assign w_sel_bready  = r_wr_idx ? s1.bready  : s0.bready;
  assign w_sel_arvalid = r_rd_idx ? s1.arvalid : s0.arvalid;
  assign w_sel_rready  = r_rd_idx ? s1.rready  : s0.rready;

  rr_arbiter2 u_wr_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      (w_wr_req),
    .i_done     (w_wr_done),
    .i_done_idx (r_wr_idx),
    .o_grant_c  (w_wr_arb_grant),
    .o_idx_c    (w_wr_arb_idx)
  );

  rr_arbiter2 u_rd_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      (w_rd_req),
    .i_done     (w_rd_done),
    .i_done_idx (r_rd_idx),
    .o_grant_c  (w_rd_arb_grant),
    .o_idx_c    (w_rd_arb_idx)
  );

  // Write FSM; forwarding enables stay low during reset so no valid/ready leaks.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_idx_nxt   = r_wr_idx;
    w_wr_grant_nxt = r_wr_grant;
    w_aw_done_nxt  = r_aw_done;
    w_w_done_nxt   = r_w_done;
    w_aw_fwd       = 1'b0;
    w_w_fwd        = 1'b0;
    w_b_fwd        = 1'b0;
    w_wr_done      = 1'b0;
    if (!rst) begin
      case (r_wr_state)
        W_IDLE: begin
          if (|w_wr_req) begin
            w_wr_state_nxt = W_ADDR;
            w_wr_idx_nxt   = w_wr_arb_idx;
            w_wr_grant_nxt = w_wr_arb_grant;
          end
        end
        W_ADDR: begin
          w_aw_fwd      = !r_aw_done;
          w_w_fwd       = !r_w_done;
          w_aw_done_nxt = r_aw_done | (w_aw_fwd & w_sel_awvalid & m.awready);
          w_w_done_nxt  = r_w_done  | (w_w_fwd  & w_sel_wvalid  & m.wready);
          if (w_aw_done_nxt && w_w_done_nxt) begin
            w_wr_state_nxt = W_RESP;
            w_aw_done_nxt  = 1'b0;
            w_w_done_nxt   = 1'b0;
          end
        end
        W_RESP: begin
          w_b_fwd = 1'b1;
          if (m.bvalid && w_sel_bready) begin
            w_wr_state_nxt = W_IDLE;
            w_wr_grant_nxt = 2'b00;
            w_wr_done      = 1'b1;
          end
        end
        default: w_wr_state_nxt = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
      r_wr_idx   <= 1'b0;
      r_wr_grant <= 2'b00;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_idx   <= w_wr_idx_nxt;
      r_wr_grant <= w_wr_grant_nxt;
      r_aw_done  <= w_aw_done_nxt;
      r_w_done   <= w_w_done_nxt;
    end
  end

  // Read FSM, same shape as the write side with a single address channel.
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_idx_nxt   = r_rd_idx;
    w_rd_grant_nxt = r_rd_grant;
    w_ar_fwd       = 1'b0;
    w_r_fwd        = 1'b0;
    w_rd_done      = 1'b0;
    if (!rst) begin
      case (r_rd_state)
        R_IDLE: begin
          if (|w_rd_req) begin
            w_rd_state_nxt = R_ADDR;
            w_rd_idx_nxt   = w_rd_arb_idx;
            w_rd_grant_nxt = w_rd_arb_grant;
          end
        end
        R_ADDR: begin
          w_ar_fwd = 1'b1;
          if (w_sel_arvalid && m.arready) w_rd_state_nxt = R_DATA;
        end
        R_DATA: begin
          w_r_fwd = 1'b1;
          if (m.rvalid && w_sel_rready) begin
            w_rd_state_nxt = R_IDLE;
            w_rd_grant_nxt = 2'b00;
            w_rd_done      = 1'b1;
          end
        end
        default: w_rd_state_nxt = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_rd_idx   <= 1'b0;
      r_rd_grant <= 2'b00;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_rd_idx   <= w_rd_idx_nxt;
      r_rd_grant <= w_rd_grant_nxt;
    end
  end

  assign wr_grant = r_wr_grant;
  assign rd_grant = r_rd_grant;

  // Downstream requests: payload muxed by owner, valids gated by FSM phase.
  assign m.awaddr  = ADDR_WIDTH'(r_wr_idx ? s1.awaddr : s0.awaddr);
  assign m.awprot  = PROT_WIDTH'(r_wr_idx ? s1.awprot : s0.awprot);
  assign m.awvalid = w_aw_fwd & w_sel_awvalid;
  assign m.wdata   = DATA_WIDTH'(r_wr_idx ? s1.wdata : s0.wdata);
  assign m.wstrb   = STRB_WIDTH'(r_wr_idx ? s1.wstrb : s0.wstrb);
  assign m.wvalid  = w_w_fwd & w_sel_wvalid;
  assign m.bready  = w_b_fwd & w_sel_bready;
  assign m.araddr  = ADDR_WIDTH'(r_rd_idx ? s1.araddr : s0.araddr);
  assign m.arprot  = PROT_WIDTH'(r_rd_idx ? s1.arprot : s0.arprot);
  assign m.arvalid = w_ar_fwd & w_sel_arvalid;
  assign m.rready  = w_r_fwd & w_sel_rready;

  // Upstream responses reach only the owning requester.
  assign s0.awready = w_aw_fwd & m.awready & (r_wr_idx == 1'b0);
  assign s1.awready = w_aw_fwd & m.awready & (r_wr_idx == 1'b1);
  assign s0.wready  = w_w_fwd  & m.wready  & (r_wr_idx == 1'b0);
  assign s1.wready  = w_w_fwd  & m.wready  & (r_wr_idx == 1'b1);
  assign s0.bvalid  = w_b_fwd  & m.bvalid  & (r_wr_idx == 1'b0);
  assign s1.bvalid  = w_b_fwd  & m.bvalid  & (r_wr_idx == 1'b1);
  assign s0.bresp   = m.bresp;
  assign s1.bresp   = m.bresp;
  assign s0.arready = w_ar_fwd & m.arready & (r_rd_idx == 1'b0);
  assign s1.arready = w_ar_fwd & m.arready & (r_rd_idx == 1'b1);
  assign s0.rvalid  = w_r_fwd  & m.rvalid  & (r_rd_idx == 1'b0);
  assign s1.rvalid  = w_r_fwd  & m.rvalid  & (r_rd_idx == 1'b1);
  assign s0.rdata   = m.rdata;
  assign s1.rdata   = m.rdata;
  assign s0.rresp   = m.rresp;
  assign s1.rresp   = m.rresp;

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Directed bench for axi4_lite_arbiter: drives both requesters and the
// downstream slave cycle by cycle and compares against hand-derived values.
module tb_axi4_lite_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] wr_grant, rd_grant;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  axi4_lite_if s0_if ();
  axi4_lite_if s1_if ();
  axi4_lite_if m_if ();

  axi4_lite_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .s0       (s0_if),
    .s1       (s1_if),
    .m        (m_if),
    .wr_grant (wr_grant),
    .rd_grant (rd_grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s0_if.awaddr = '0; s0_if.awprot = '0; s0_if.awvalid = 1'b0;
    s0_if.wdata  = '0; s0_if.wstrb  = '0; s0_if.wvalid  = 1'b0; s0_if.bready = 1'b1;
    s0_if.araddr = '0; s0_if.arprot = '0; s0_if.arvalid = 1'b0; s0_if.rready = 1'b1;
    s1_if.awaddr = '0; s1_if.awprot = '0; s1_if.awvalid = 1'b0;
    s1_if.wdata  = '0; s1_if.wstrb  = '0; s1_if.wvalid  = 1'b0; s1_if.bready = 1'b1;
    s1_if.araddr = '0; s1_if.arprot = '0; s1_if.arvalid = 1'b0; s1_if.rready = 1'b1;
    m_if.awready = 1'b1; m_if.wready = 1'b1; m_if.arready = 1'b1;
    m_if.bvalid  = 1'b0; m_if.bresp  = 2'b00;
    m_if.rvalid  = 1'b0; m_if.rresp  = 2'b00; m_if.rdata = '0;
  endtask

  // Entered in the cycle rd_grant has just become `who`; completes AR then R.
  task automatic read_beat(input int who, input logic [31:0] addr, input logic [31:0] data,
                           input string tag);
    check({tag, "_grant"}, 64'(rd_grant), (who == 1) ? 64'd2 : 64'd1);
    check({tag, "_araddr"}, 64'(m_if.araddr), 64'(addr));
    check({tag, "_arvalid"}, 64'(m_if.arvalid), 64'd1);
    tick();
    if (who == 1) s1_if.arvalid = 1'b0; else s0_if.arvalid = 1'b0;
    m_if.rvalid = 1'b1;
    m_if.rdata  = data;
    #1;
    check({tag, "_rvalid_own"}, (who == 1) ? 64'(s1_if.rvalid) : 64'(s0_if.rvalid), 64'd1);
    check({tag, "_rvalid_other"}, (who == 1) ? 64'(s0_if.rvalid) : 64'(s1_if.rvalid), 64'd0);
    check({tag, "_rdata"}, (who == 1) ? 64'(s1_if.rdata) : 64'(s0_if.rdata), 64'(data));
    tick();
    m_if.rvalid = 1'b0;
    #1;
    check({tag, "_grant_idle"}, 64'(rd_grant), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    s0_if.awvalid = 1'b1;
    s1_if.arvalid = 1'b1;
    #1;
    check("rst_s0_awready", 64'(s0_if.awready), 64'd0);
    check("rst_s1_arready", 64'(s1_if.arready), 64'd0);
    check("rst_m_awvalid", 64'(m_if.awvalid), 64'd0);
    check("rst_m_arvalid", 64'(m_if.arvalid), 64'd0);
    tick();
    tick();
    check("rst_wr_grant", 64'(wr_grant), 64'd0);
    check("rst_rd_grant", 64'(rd_grant), 64'd0);
    rst = 1'b0;
    s0_if.awvalid = 1'b0;
    s1_if.arvalid = 1'b0;
    #1;
    check("idle_m_bready", 64'(m_if.bready), 64'd0);
    check("idle_m_rready", 64'(m_if.rready), 64'd0);

    // Lone write from s0
    s0_if.awvalid = 1'b1; s0_if.awaddr = 32'h10;
    s0_if.wvalid  = 1'b1; s0_if.wdata  = 32'hDEADBEEF; s0_if.wstrb = 4'hF;
    #1;
    check("w1_cycle0_awvalid", 64'(m_if.awvalid), 64'd0);
    tick();
    check("w1_grant", 64'(wr_grant), 64'd1);
    check("w1_awvalid", 64'(m_if.awvalid), 64'd1);
    check("w1_awaddr", 64'(m_if.awaddr), 64'h10);
    check("w1_wdata", 64'(m_if.wdata), 64'hDEADBEEF);
    check("w1_wstrb", 64'(m_if.wstrb), 64'hF);
    check("w1_s0_awready", 64'(s0_if.awready), 64'd1);
    check("w1_s1_awready", 64'(s1_if.awready), 64'd0);
    check("w1_bready_early", 64'(m_if.bready), 64'd0);
    tick();
    s0_if.awvalid = 1'b0; s0_if.wvalid = 1'b0;
    m_if.bvalid = 1'b1; m_if.bresp = 2'b00;
    #1;
    check("w1_s0_bvalid", 64'(s0_if.bvalid), 64'd1);
    check("w1_s0_bresp", 64'(s0_if.bresp), 64'd0);
    check("w1_s1_bvalid", 64'(s1_if.bvalid), 64'd0);
    check("w1_m_bready", 64'(m_if.bready), 64'd1);
    tick();
    m_if.bvalid = 1'b0;
    #1;
    check("w1_grant_idle", 64'(wr_grant), 64'd0);

    // Read contention and pointer alternation
    s0_if.arvalid = 1'b1; s0_if.araddr = 32'h100;
    s1_if.arvalid = 1'b1; s1_if.araddr = 32'h200;
    #1;
    check("rr_cycle0_grant", 64'(rd_grant), 64'd0);
    tick();
    check("rr1_s1_arready", 64'(s1_if.arready), 64'd0);
    read_beat(0, 32'h100, 32'hA0A0_0001, "rr1");
    s0_if.arvalid = 1'b1; s0_if.araddr = 32'h104;
    tick();
    read_beat(1, 32'h200, 32'hB0B0_0001, "rr2");
    tick();
    read_beat(0, 32'h104, 32'hA0A0_0002, "rr3");
    s0_if.arvalid = 1'b1; s0_if.araddr = 32'h108;
    s1_if.arvalid = 1'b1; s1_if.araddr = 32'h204;
    tick();
    read_beat(1, 32'h204, 32'hB0B0_0002, "rr4");
    tick();
    read_beat(0, 32'h108, 32'hA0A0_0003, "rr5");

    // Concurrent write (s0) and read (s1)
    s0_if.awvalid = 1'b1; s0_if.awaddr = 32'h30; s0_if.wvalid = 1'b1; s0_if.wdata = 32'h1234;
    s1_if.arvalid = 1'b1; s1_if.araddr = 32'h300;
    tick();
    check("cc_wr_grant", 64'(wr_grant), 64'd1);
    check("cc_rd_grant", 64'(rd_grant), 64'd2);
    tick();
    s0_if.awvalid = 1'b0; s0_if.wvalid = 1'b0; s1_if.arvalid = 1'b0;
    m_if.bvalid = 1'b1; m_if.rvalid = 1'b1; m_if.rdata = 32'hC0C0;
    #1;
    check("cc_s0_bvalid", 64'(s0_if.bvalid), 64'd1);
    check("cc_s1_bvalid", 64'(s1_if.bvalid), 64'd0);
    check("cc_s1_rvalid", 64'(s1_if.rvalid), 64'd1);
    check("cc_s0_rvalid", 64'(s0_if.rvalid), 64'd0);
    tick();
    m_if.bvalid = 1'b0; m_if.rvalid = 1'b0;
    #1;
    check("cc_wr_idle", 64'(wr_grant), 64'd0);
    check("cc_rd_idle", 64'(rd_grant), 64'd0);

    // Split AW/W: W accepted three cycles ahead of AW; s1 waits on the side
    m_if.awready = 1'b0;
    s0_if.awvalid = 1'b1; s0_if.awaddr = 32'h40; s0_if.wvalid = 1'b1; s0_if.wdata = 32'h4444;
    tick();
    check("sp_grant", 64'(wr_grant), 64'd1);
    check("sp_wvalid", 64'(m_if.wvalid), 64'd1);
    check("sp_bready_c1", 64'(m_if.bready), 64'd0);
    s1_if.awvalid = 1'b1; s1_if.awaddr = 32'h50; s1_if.wvalid = 1'b1; s1_if.wdata = 32'h5555;
    #1;
    check("sp_s1_awready_c1", 64'(s1_if.awready), 64'd0);
    check("sp_s1_wready_c1", 64'(s1_if.wready), 64'd0);
    tick();
    s0_if.wvalid = 1'b0;
    #1;
    check("sp_wvalid_done", 64'(m_if.wvalid), 64'd0);
    check("sp_awvalid_held", 64'(m_if.awvalid), 64'd1);
    check("sp_bready_c2", 64'(m_if.bready), 64'd0);
    check("sp_s1_awready_c2", 64'(s1_if.awready), 64'd0);
    tick();
    check("sp_bready_c3", 64'(m_if.bready), 64'd0);
    check("sp_grant_c3", 64'(wr_grant), 64'd1);
    tick();
    m_if.awready = 1'b1;
    #1;
    check("sp_s0_awready_c4", 64'(s0_if.awready), 64'd1);
    check("sp_s1_awready_c4", 64'(s1_if.awready), 64'd0);
    check("sp_bready_c4", 64'(m_if.bready), 64'd0);
    tick();
    s0_if.awvalid = 1'b0;
    #1;
    check("sp_bready_resp", 64'(m_if.bready), 64'd1);
    check("sp_awvalid_resp", 64'(m_if.awvalid), 64'd0);
    check("sp_s1_awready_resp", 64'(s1_if.awready), 64'd0);
    m_if.bvalid = 1'b1;
    #1;
    check("sp_s0_bvalid", 64'(s0_if.bvalid), 64'd1);
    check("sp_s1_bvalid", 64'(s1_if.bvalid), 64'd0);
    tick();
    m_if.bvalid = 1'b0;
    tick();
    check("sp_s1_grant", 64'(wr_grant), 64'd2);
    check("sp_s1_awaddr", 64'(m_if.awaddr), 64'h50);
    check("sp_s1_wdata", 64'(m_if.wdata), 64'h5555);
    check("sp_s0_awready_s1", 64'(s0_if.awready), 64'd0);
    tick();
    s1_if.awvalid = 1'b0; s1_if.wvalid = 1'b0; m_if.bvalid = 1'b1;
    #1;
    check("sp_s1_bvalid_own", 64'(s1_if.bvalid), 64'd1);
    check("sp_s0_bvalid_other", 64'(s0_if.bvalid), 64'd0);
    tick();
    m_if.bvalid = 1'b0;
    #1;
    check("sp_grant_idle", 64'(wr_grant), 64'd0);

    // Reset while a B response is pending
    s0_if.bready = 1'b0;
    s0_if.awvalid = 1'b1; s0_if.awaddr = 32'h60; s0_if.wvalid = 1'b1;
    tick();
    tick();
    s0_if.awvalid = 1'b0; s0_if.wvalid = 1'b0; m_if.bvalid = 1'b1;
    #1;
    check("rs_bvalid_pending", 64'(s0_if.bvalid), 64'd1);
    rst = 1'b1;
    #1;
    check("rs_bvalid_in_rst", 64'(s0_if.bvalid), 64'd0);
    check("rs_bready_in_rst", 64'(m_if.bready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rs_wr_grant", 64'(wr_grant), 64'd0);
    check("rs_bvalid_after", 64'(s0_if.bvalid), 64'd0);
    m_if.bvalid = 1'b0; s0_if.bready = 1'b1;
    s1_if.awvalid = 1'b1; s1_if.awaddr = 32'h70; s1_if.wvalid = 1'b1;
    tick();
    check("rs_s1_grant", 64'(wr_grant), 64'd2);
    check("rs_s1_awaddr", 64'(m_if.awaddr), 64'h70);
    tick();
    s1_if.awvalid = 1'b0; s1_if.wvalid = 1'b0; m_if.bvalid = 1'b1;
    #1;
    check("rs_s1_bvalid", 64'(s1_if.bvalid), 64'd1);
    check("rs_s0_bvalid", 64'(s0_if.bvalid), 64'd0);
    tick();
    m_if.bvalid = 1'b0;
    #1;
    check("rs_grant_idle", 64'(wr_grant), 64'd0);

    // R back-pressure from s0 with s1 knocking
    s0_if.arvalid = 1'b1; s0_if.araddr = 32'h400; s0_if.rready = 1'b0;
    tick();
    check("bp_grant", 64'(rd_grant), 64'd1);
    tick();
    s0_if.arvalid = 1'b0; s1_if.arvalid = 1'b1; s1_if.araddr = 32'h404;
    m_if.rvalid = 1'b1; m_if.rdata = 32'h55AA;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_m_rready", 64'(m_if.rready), 64'd0);
      check("bp_s0_rvalid", 64'(s0_if.rvalid), 64'd1);
      check("bp_s0_rdata", 64'(s0_if.rdata), 64'h55AA);
      check("bp_grant_held", 64'(rd_grant), 64'd1);
      tick();
    end
    s0_if.rready = 1'b1;
    #1;
    check("bp_m_rready_rel", 64'(m_if.rready), 64'd1);
    tick();
    m_if.rvalid = 1'b0;
    #1;
    check("bp_grant_idle", 64'(rd_grant), 64'd0);
    tick();
    read_beat(1, 32'h404, 32'hB0B0_0003, "bp_s1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
